dmem_arb: RTL and testbench
===========================

// Module: dmem_arb
// PURPOSE
//  Arbitrates one port of the data memory between NREQ requesters (req 0 = MA/MO pipeline
//  stage, others = loader/debug/DMA). Each cycle selects at most one winner, drives the
//  memory port combinationally, and routes the 1-cycle-latency read data back to the winner.
//  Supports fixed priority for req 0, round-robin among the rest, bus locking, and starvation override.
// PARAMETERS
//  NREQ      2           number of requesters (2..8)
//  AW        `SIZE_ADDR  address width
//  DW        `SIZE_DATA  data width
//  PRIO0     1           1: req 0 has fixed priority; 0: all requesters round-robin
//  MAX_WAIT  8           consecutive denied cycles before a requester is starved (1..255)
//  LOCK_MAX  16          max consecutive locked grants to one owner (1..255)
// PORTS
//  iw_clk        in   1        clock, rising edge
//  iw_rst_n      in   1        asynchronous reset, active low
//  iw_req        in   NREQ     request per requester; held with payload until ack
//  iw_lock       in   NREQ     keep grant after this access (burst)
//  iw_we         in   NREQ     1 = write, 0 = read
//  iw_addr       in   NREQ*AW  packed addresses, requester i at [i*AW +: AW]
//  iw_wdata      in   NREQ*DW  packed write data
//  ow_ack        out  NREQ     one-hot; access performed this cycle
//  ow_rvalid     out  NREQ     one-hot; read data valid for requester i
//  ow_rdata      out  DW       read data (broadcast; qualify with ow_rvalid)
//  ow_mem_we     out  1        memory write enable
//  ow_mem_addr   out  AW       memory address
//  ow_mem_wdata  out  DW       memory write data
//  iw_mem_rdata  in   DW       memory read data, valid 1 cycle after address
// BEHAVIOUR
//  - Reset (iw_rst_n=0, async): rr pointer=NREQ-1, lock idle, all wait counters=0,
//    lock counter=0, ow_rvalid=0; while in reset ow_ack=0, ow_mem_we=0, addr/wdata=0.
//  - Winner chosen combinationally from current iw_req and registered state, in order:
//    1. LOCKED state and iw_req[owner]=1 and lock count<LOCK_MAX -> owner.
//    2. Any requester with wait count==MAX_WAIT -> lowest such index.
//    3. PRIO0=1 and iw_req[0] -> req 0.
//    4. Round-robin: first requesting index after rr pointer (wrap NREQ-1 -> 0).
//  - No request -> no winner: ow_ack=0, ow_mem_we=0, mem addr/wdata=0.
//  - Winner w: ow_ack[w]=1, ow_mem_we=iw_we[w], addr/wdata muxed from slot w, same cycle.
//  - Read latency: ack on read at cycle N -> ow_rvalid[w]=1 and ow_rdata=iw_mem_rdata at N+1.
//    Writes never produce rvalid. Back-to-back reads by any mix of requesters: 1 per cycle.
//  - rr pointer <= w on every grant from step 4 only; priority/starved/locked grants leave it.
//  - Wait counters: requesting and not acked -> +1, saturating at MAX_WAIT; acked or
//    not requesting -> 0.
//  - Lock FSM IDLE/LOCKED: IDLE->LOCKED when winner has iw_lock=1 (owner=w, count=1).
//    LOCKED: owner ack with iw_lock=1 -> count+1; ack with iw_lock=0 or owner drops
//    iw_req -> IDLE. count==LOCK_MAX -> lock ignored for one arbitration, FSM -> IDLE;
//    winner then re-chosen by steps 2-4 (owner may relock if it wins again).
//  - Lock overrides starvation and PRIO0; starvation overrides PRIO0 and round-robin.
//  - Requester dropping iw_req without ack is legal; its counter clears next cycle.
//  - Reset mid-read: pending ow_rvalid discarded (0 on reset assertion).
//  - Invariants: ow_ack and ow_rvalid each one-hot-or-zero; ack only where iw_req=1.
// TESTING
//  1. NREQ=2,PRIO0=1: req0 read addr 0x10 and req1 read 0x20 same cycle -> ack=01,
//     mem_addr=0x10; next cycle rvalid=01, ack=10 only if req0 dropped.
//  2. PRIO0=1, req0 held continuously, req1 held: req1 acked on 9th cycle (MAX_WAIT=8),
//     req0 acked other 8; rvalid follows each read ack by exactly 1 cycle.
//  3. PRIO0=0, NREQ=4, all requesting: ack order 0,1,2,3,0,... ; rr wraps 3->0.
//  4. req1 iw_lock=1 for 20 writes, req0 requesting: req1 acked 16 consecutive cycles,
//     then req0 acked once, then req1 relocks; mem_we=1 on every req1 ack.
//  5. Read acked at N, iw_rst_n pulsed low at N+0.5 -> ow_rvalid=0 at N+1, counters=0,
//     lock IDLE; first grant after release is round-robin from index 0.
//  6. No requests for 10 cycles -> ack=0, mem_we=0, rvalid=0 throughout.

Source files
------------

// File: rtl/dmem_arb.sv
// rtl/dmem_arb.sv - data memory port arbiter with priority, round-robin, lock and starvation override
//
// Ports:
//   iw_clk, iw_rst_n          clock (rising edge), asynchronous active-low reset
//   iw_req/iw_lock/iw_we      per-requester request, burst lock, write enable
//   iw_addr/iw_wdata          packed per-requester address / write data
//   ow_ack/ow_rvalid          one-hot grant this cycle / read data valid this cycle
//   ow_rdata                  broadcast read data, qualified by ow_rvalid
//   ow_mem_we/addr/wdata      memory port driven combinationally from the winner
//   iw_mem_rdata              memory read data, one cycle after the address

`ifndef SIZE_ADDR
`define SIZE_ADDR 32
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

module dmem_arb #(
   parameter int NREQ     = 2,
   parameter int AW       = `SIZE_ADDR,
   parameter int DW       = `SIZE_DATA,
   parameter int PRIO0    = 1,
   parameter int MAX_WAIT = 8,
   parameter int LOCK_MAX = 16
) (
   input  logic               iw_clk,
   input  logic               iw_rst_n,
   input  logic [NREQ-1:0]    iw_req,
   input  logic [NREQ-1:0]    iw_lock,
   input  logic [NREQ-1:0]    iw_we,
   input  logic [NREQ*AW-1:0] iw_addr,
   input  logic [NREQ*DW-1:0] iw_wdata,
   output logic [NREQ-1:0]    ow_ack,
   output logic [NREQ-1:0]    ow_rvalid,
   output logic [DW-1:0]      ow_rdata,
   output logic               ow_mem_we,
   output logic [AW-1:0]      ow_mem_addr,
   output logic [DW-1:0]      ow_mem_wdata,
   input  logic [DW-1:0]      iw_mem_rdata
);

   localparam int IW = $clog2(NREQ);
   localparam int WW = $clog2(MAX_WAIT + 1);
   localparam int LW = $clog2(LOCK_MAX + 1);

   typedef enum logic {
      L_IDLE   = 1'b0,
      L_LOCKED = 1'b1
   } lock_e;

   lock_e            lock_q, lock_d;
   logic [IW-1:0]    owner_q, owner_d;
   logic [IW-1:0]    rr_q, rr_d;
   logic [LW-1:0]    lcnt_q, lcnt_d;
   logic [WW-1:0]    wait_q [NREQ];
   logic [WW-1:0]    wait_d [NREQ];
   logic [NREQ-1:0]  rvalid_q, rvalid_d;

   logic             lock_hit;
   logic             st_vld, rr_vld;
   logic [IW-1:0]    st_idx, rr_idx;
   logic             win_vld, win_rr;
   logic [IW-1:0]    win_idx;
   int               rr_cand;

   // Winner selection: lock, then starvation, then fixed priority, then round-robin.
   always_comb begin : arbitrate
      lock_hit = (lock_q == L_LOCKED) && iw_req[owner_q] && (lcnt_q < LW'(LOCK_MAX));

      // Downward scans so the last hit is the lowest index / nearest after the pointer.
      st_vld = 1'b0;
      st_idx = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (iw_req[i] && (wait_q[i] == WW'(MAX_WAIT))) begin
            st_vld = 1'b1;
            st_idx = IW'(i);
         end
      end

      rr_vld  = 1'b0;
      rr_idx  = '0;
      rr_cand = 0;
      for (int k = NREQ; k >= 1; k--) begin
         rr_cand = int'(rr_q) + k;
         if (rr_cand >= NREQ) rr_cand = rr_cand - NREQ;
         if (iw_req[rr_cand]) begin
            rr_vld = 1'b1;
            rr_idx = IW'(rr_cand);
         end
      end

      win_vld = 1'b0;
      win_rr  = 1'b0;
      win_idx = '0;
      if (lock_hit) begin
         win_vld = 1'b1;
         win_idx = owner_q;
      end else if (st_vld) begin
         win_vld = 1'b1;
         win_idx = st_idx;
      end else if ((PRIO0 != 0) && iw_req[0]) begin
         win_vld = 1'b1;
         win_idx = '0;
      end else if (rr_vld) begin
         win_vld = 1'b1;
         win_rr  = 1'b1;
         win_idx = rr_idx;
      end
   end

   always_ff @(posedge iw_clk or negedge iw_rst_n) begin
      if (!iw_rst_n) begin
         lock_q   <= L_IDLE;
         owner_q  <= '0;
         rr_q     <= IW'(NREQ - 1);
         lcnt_q   <= '0;
         rvalid_q <= '0;
         for (int i = 0; i < NREQ; i++) wait_q[i] <= '0;
      end else begin
         lock_q   <= lock_d;
         owner_q  <= owner_d;
         rr_q     <= rr_d;
         lcnt_q   <= lcnt_d;
         rvalid_q <= rvalid_d;
         for (int i = 0; i < NREQ; i++) wait_q[i] <= wait_d[i];
      end
   end

   always_comb begin : next_state
      rr_d = (win_vld && win_rr) ? win_idx : rr_q;

      for (int i = 0; i < NREQ; i++) begin
         wait_d[i] = '0;
         if (iw_req[i] && !(win_vld && (win_idx == IW'(i)))) begin
            wait_d[i] = (wait_q[i] == WW'(MAX_WAIT)) ? wait_q[i] : wait_q[i] + WW'(1);
         end
      end

      lock_d  = lock_q;
      owner_d = owner_q;
      lcnt_d  = lcnt_q;
      if (lock_hit) begin
         if (iw_lock[owner_q]) begin
            lcnt_d = lcnt_q + LW'(1);
         end else begin
            lock_d = L_IDLE;
            lcnt_d = '0;
         end
      end else if (win_vld && iw_lock[win_idx]) begin
         // Covers a fresh lock, and an exhausted/abandoned lock re-taken by whoever won.
         lock_d  = L_LOCKED;
         owner_d = win_idx;
         lcnt_d  = LW'(1);
      end else begin
         lock_d = L_IDLE;
         lcnt_d = '0;
      end

      rvalid_d = '0;
      if (win_vld && !iw_we[win_idx]) rvalid_d[win_idx] = 1'b1;
   end

   // Grant and memory port are forced quiet while reset is asserted.
   always_comb begin : outputs
      ow_ack       = '0;
      ow_mem_we    = 1'b0;
      ow_mem_addr  = '0;
      ow_mem_wdata = '0;
      if (iw_rst_n && win_vld) begin
         ow_ack[win_idx] = 1'b1;
         ow_mem_we       = iw_we[win_idx];
         ow_mem_addr     = iw_addr[win_idx*AW +: AW];
         ow_mem_wdata    = iw_wdata[win_idx*DW +: DW];
      end
      ow_rvalid = rvalid_q;
      ow_rdata  = iw_mem_rdata;
   end

endmodule

// File: tb/tb_dmem_arb.sv
// tb/tb_dmem_arb.sv - self-checking bench for dmem_arb (NREQ=2 PRIO0=1 and NREQ=4 PRIO0=0 instances)

module tb_dmem_arb;

   localparam int AW       = 8;
   localparam int DW       = 16;
   localparam int MAX_WAIT = 8;
   localparam int LOCK_MAX = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]  req_a, lock_a, we_a, ack_a, rv_a;
   logic [15:0] addr_a;
   logic [31:0] wdata_a;
   logic [15:0] rdata_a, mwd_a, mrd_a;
   logic [7:0]  maddr_a;
   logic        mwe_a;

   logic [3:0]  req_b, lock_b, we_b, ack_b, rv_b;
   logic [31:0] addr_b;
   logic [63:0] wdata_b;
   logic [15:0] rdata_b, mwd_b, mrd_b;
   logic [7:0]  maddr_b;
   logic        mwe_b;

   dmem_arb #(.NREQ(2), .AW(AW), .DW(DW), .PRIO0(1), .MAX_WAIT(MAX_WAIT), .LOCK_MAX(LOCK_MAX)) u_a (
      .iw_clk(clk), .iw_rst_n(rst_n), .iw_req(req_a), .iw_lock(lock_a), .iw_we(we_a),
      .iw_addr(addr_a), .iw_wdata(wdata_a), .ow_ack(ack_a), .ow_rvalid(rv_a), .ow_rdata(rdata_a),
      .ow_mem_we(mwe_a), .ow_mem_addr(maddr_a), .ow_mem_wdata(mwd_a), .iw_mem_rdata(mrd_a));

   dmem_arb #(.NREQ(4), .AW(AW), .DW(DW), .PRIO0(0), .MAX_WAIT(MAX_WAIT), .LOCK_MAX(LOCK_MAX)) u_b (
      .iw_clk(clk), .iw_rst_n(rst_n), .iw_req(req_b), .iw_lock(lock_b), .iw_we(we_b),
      .iw_addr(addr_b), .iw_wdata(wdata_b), .ow_ack(ack_b), .ow_rvalid(rv_b), .ow_rdata(rdata_b),
      .ow_mem_we(mwe_b), .ow_mem_addr(maddr_b), .ow_mem_wdata(mwd_b), .iw_mem_rdata(mrd_b));

   // Requester stimulus, per DUT (0 = a, 1 = b) and per requester
   bit          t_req  [2][4];
   bit          t_lock [2][4];
   bit          t_we   [2][4];
   logic [7:0]  t_addr [2][4];
   logic [15:0] t_wdata[2][4];
   int          nq[2] = '{2, 4};
   int          p0[2] = '{1, 0};

   // Reference model state
   int          m_rr[2], m_owner[2], m_lcnt[2], m_rv[2];
   int          m_wait[2][4];
   bit          m_locked[2];
   logic [15:0] m_rd[2];
   logic [15:0] mem[2][256];

   int          win[2], kind[2];
   logic [31:0] o_ack[2], o_rv[2];
   logic [31:0] o_addr[2];
   int          total = 0, bad = 0;
   bit          auto_mode = 0;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset(int d);
      m_rr[d] = nq[d] - 1;
      m_locked[d] = 0;
      m_owner[d] = 0;
      m_lcnt[d] = 0;
      m_rv[d] = -1;
      for (int i = 0; i < 4; i++) m_wait[d][i] = 0;
   endtask

   task automatic clr_all();
      for (int d = 0; d < 2; d++)
         for (int i = 0; i < 4; i++) begin
            t_req[d][i] = 0; t_lock[d][i] = 0; t_we[d][i] = 0;
            t_addr[d][i] = '0; t_wdata[d][i] = '0;
         end
   endtask

   task automatic set_req(int d, int i, bit we, bit lk, logic [7:0] a, logic [15:0] wd);
      t_req[d][i] = 1; t_we[d][i] = we; t_lock[d][i] = lk;
      t_addr[d][i] = a; t_wdata[d][i] = wd;
   endtask

   // Winner per the arbitration rules; k: 1 lock, 2 starved, 3 priority, 4 round-robin
   function automatic int pick(int d, output int k);
      k = 0;
      if (m_locked[d] && t_req[d][m_owner[d]] && m_lcnt[d] < LOCK_MAX) begin
         k = 1;
         return m_owner[d];
      end
      for (int i = 0; i < nq[d]; i++)
         if (t_req[d][i] && m_wait[d][i] == MAX_WAIT) begin
            k = 2;
            return i;
         end
      if (p0[d] != 0 && t_req[d][0]) begin
         k = 3;
         return 0;
      end
      for (int j = 1; j <= nq[d]; j++) begin
         int i;
         i = (m_rr[d] + j) % nq[d];
         if (t_req[d][i]) begin
            k = 4;
            return i;
         end
      end
      return -1;
   endfunction

   task automatic model_update(int d);
      int w;
      w = win[d];
      if (kind[d] == 4) m_rr[d] = w;
      for (int i = 0; i < nq[d]; i++)
         if (t_req[d][i] && i != w) m_wait[d][i] = (m_wait[d][i] < MAX_WAIT) ? m_wait[d][i] + 1 : MAX_WAIT;
         else m_wait[d][i] = 0;
      if (kind[d] == 1) begin
         if (t_lock[d][w]) m_lcnt[d]++;
         else m_locked[d] = 0;
      end else if (w >= 0 && t_lock[d][w]) begin
         m_locked[d] = 1; m_owner[d] = w; m_lcnt[d] = 1;
      end else m_locked[d] = 0;
      if (w >= 0 && !t_we[d][w]) begin
         m_rv[d] = w;
         m_rd[d] = mem[d][t_addr[d][w]];
      end else m_rv[d] = -1;
      if (w >= 0 && t_we[d][w]) mem[d][t_addr[d][w]] = t_wdata[d][w];
      if (auto_mode)
         for (int i = 0; i < nq[d]; i++) begin
            if (!t_req[d][i] || i == w) begin
               t_req[d][i] = 0;
               if ($urandom_range(9) < 6)
                  set_req(d, i, 1'($urandom), ($urandom_range(7) == 0),
                          8'($urandom_range(15)), 16'($urandom));
            end else if ($urandom_range(31) == 0) t_req[d][i] = 0;
         end
   endtask

   task automatic apply();
      for (int i = 0; i < 2; i++) begin
         req_a[i] = t_req[0][i]; lock_a[i] = t_lock[0][i]; we_a[i] = t_we[0][i];
         addr_a[i*AW +: AW] = t_addr[0][i]; wdata_a[i*DW +: DW] = t_wdata[0][i];
      end
      for (int i = 0; i < 4; i++) begin
         req_b[i] = t_req[1][i]; lock_b[i] = t_lock[1][i]; we_b[i] = t_we[1][i];
         addr_b[i*AW +: AW] = t_addr[1][i]; wdata_b[i*DW +: DW] = t_wdata[1][i];
      end
      mrd_a = (m_rv[0] >= 0) ? m_rd[0] : 16'($urandom);
      mrd_b = (m_rv[1] >= 0) ? m_rd[1] : 16'($urandom);
   endtask

   task automatic check_dut(int d);
      logic [31:0] e_ack, e_we, e_addr, e_wd, e_rv, ow, owd, ord;
      string n;
      n = (d == 0) ? "a" : "b";
      if (d == 0) begin
         o_ack[d] = {30'b0, ack_a}; o_rv[d] = {30'b0, rv_a};
         o_addr[d] = {24'b0, maddr_a}; ow = {31'b0, mwe_a}; owd = {16'b0, mwd_a}; ord = {16'b0, rdata_a};
      end else begin
         o_ack[d] = {28'b0, ack_b}; o_rv[d] = {28'b0, rv_b};
         o_addr[d] = {24'b0, maddr_b}; ow = {31'b0, mwe_b}; owd = {16'b0, mwd_b}; ord = {16'b0, rdata_b};
      end
      e_ack = 0; e_we = 0; e_addr = 0; e_wd = 0;
      if (rst_n && win[d] >= 0) begin
         e_ack  = 32'(1) << win[d];
         e_we   = {31'b0, t_we[d][win[d]]};
         e_addr = {24'b0, t_addr[d][win[d]]};
         e_wd   = {16'b0, t_wdata[d][win[d]]};
      end
      e_rv = (rst_n && m_rv[d] >= 0) ? (32'(1) << m_rv[d]) : 32'(0);
      chk({n, "_ack"}, o_ack[d], e_ack);
      chk({n, "_mem_we"}, ow, e_we);
      chk({n, "_mem_addr"}, o_addr[d], e_addr);
      chk({n, "_mem_wdata"}, owd, e_wd);
      chk({n, "_rvalid"}, o_rv[d], e_rv);
      if (e_rv != 0) chk({n, "_rdata"}, ord, {16'b0, m_rd[d]});
   endtask

   // One clock: drive after the falling edge, check, then advance the model at the rising edge
   task automatic cycle();
      apply();
      #1;
      for (int d = 0; d < 2; d++) begin
         if (rst_n) win[d] = pick(d, kind[d]);
         else begin win[d] = -1; kind[d] = 0; end
         check_dut(d);
      end
      @(posedge clk);
      for (int d = 0; d < 2; d++)
         if (rst_n) model_update(d);
         else model_reset(d);
      @(negedge clk);
   endtask

   initial begin
      int n1, first, ncyc, run;
      logic [31:0] seq[64];
      logic [31:0] bseq[8];
      logic [31:0] acc;

      for (int d = 0; d < 2; d++) begin
         model_reset(d);
         for (int a = 0; a < 256; a++) mem[d][a] = {8'(8'hC3 + d), 8'(a)};
      end
      clr_all();

      // Reset: requests present but everything quiet
      set_req(0, 0, 0, 0, 8'h05, 16'h0);
      for (int i = 0; i < 4; i++) set_req(1, i, 1, 0, 8'(i), 16'h1234);
      @(negedge clk);
      cycle();
      cycle();
      rst_n = 1'b1;
      clr_all();
      cycle();

      // Fixed priority on a, rotation 0,1,2,3,0.. on b
      set_req(0, 0, 0, 0, 8'h10, 16'h0);
      set_req(0, 1, 0, 0, 8'h20, 16'h0);
      for (int i = 0; i < 4; i++) set_req(1, i, 1, 0, 8'(8'h30 + i), 16'(16'hB000 + i));
      cycle();
      chk("t1_ack_first", o_ack[0], 32'h1);
      chk("t1_addr_first", o_addr[0], 32'h10);
      bseq[0] = o_ack[1];
      t_req[0][0] = 0;
      cycle();
      chk("t1_rvalid_req0", o_rv[0], 32'h1);
      chk("t1_ack_req1", o_ack[0], 32'h2);
      bseq[1] = o_ack[1];
      t_req[0][1] = 0;
      for (int c = 2; c < 8; c++) begin
         cycle();
         bseq[c] = o_ack[1];
      end
      for (int c = 0; c < 8; c++) chk($sformatf("t3_rr_order_%0d", c), bseq[c], 32'(1) << (c % 4));
      clr_all();
      cycle();

      // Starvation: req1 gets through on every 9th cycle
      set_req(0, 0, 0, 0, 8'h40, 16'h0);
      set_req(0, 1, 0, 0, 8'h44, 16'h0);
      n1 = 0;
      first = -1;
      for (int c = 0; c < 18; c++) begin
         cycle();
         if (o_ack[0] == 32'h2) begin
            if (first < 0) first = c;
            n1++;
         end
      end
      chk("t2_req1_acks", n1, 2);
      chk("t2_req1_first", first, 8);
      clr_all();
      cycle();

      // Lock burst limit: 16 locked writes, one starved req0 read, then relock
      set_req(0, 1, 1, 1, 8'h50, 16'h1000);
      n1 = 0;
      ncyc = 0;
      while (n1 < 20 && ncyc < 60) begin
         if (ncyc == 1) set_req(0, 0, 0, 0, 8'h60, 16'h0);
         cycle();
         seq[ncyc] = o_ack[0];
         if (win[0] == 1) begin
            n1++;
            t_wdata[0][1] = t_wdata[0][1] + 16'h1;
            t_addr[0][1] = t_addr[0][1] + 8'h1;
            if (n1 == 20) begin t_req[0][1] = 0; t_lock[0][1] = 0; end
         end
         if (win[0] == 0) t_req[0][0] = 0;
         ncyc++;
      end
      chk("t4_all_writes_done", n1, 20);
      run = 0;
      while (run < 60 && seq[run] == 32'h2) run++;
      chk("t4_locked_run", run, 16);
      chk("t4_req0_after_lock", seq[16], 32'h1);
      chk("t4_relock", seq[17], 32'h2);
      clr_all();
      cycle();

      // Reset during a pending read
      set_req(0, 0, 0, 0, 8'h20, 16'h0);
      set_req(1, 2, 1, 1, 8'h70, 16'hAAAA);
      cycle();
      chk("t5_rvalid_pending", {30'b0, rv_a}, 32'h1);
      clr_all();
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) model_reset(d);
      #1;
      chk("t5_rvalid_dropped", {30'b0, rv_a}, 32'h0);
      set_req(0, 1, 0, 0, 8'h21, 16'h0);
      cycle();
      rst_n = 1'b1;
      clr_all();
      set_req(1, 1, 1, 0, 8'h71, 16'h1111);
      set_req(1, 2, 1, 1, 8'h72, 16'h2222);
      cycle();
      chk("t5_first_grant_rr", o_ack[1], 32'h2);
      clr_all();
      cycle();

      // Idle
      acc = 0;
      for (int c = 0; c < 10; c++) begin
         cycle();
         acc = acc | o_ack[0] | o_ack[1] | o_rv[0] | o_rv[1] | {31'b0, mwe_a} | {31'b0, mwe_b};
      end
      chk("t6_idle_quiet", acc, 32'h0);

      // Random traffic against the model
      auto_mode = 1;
      for (int c = 0; c < 400; c++) cycle();
      auto_mode = 0;
      clr_all();
      cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
